// File: rtl/mem_access_unit_if.sv
// Data-bus (MIO) signal bundle between the memory-stage access unit and the bus.
// Latency: none, wiring only.
// Backpressure: bus_ready from the slave holds the master's request until it is accepted.
//
// Ports (master = access unit, slave = bus/memory side):
//   bus_req    transaction request
//   bus_we     write strobe
//   bus_be     byte enables, bit i covers bits [8i+7:8i]
//   bus_addr   word-aligned address
//   bus_wdata  lane-replicated store data
//   bus_rdata  read data returned by the bus
//   bus_ready  bus completes the current access
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: sized loads/stores -> word-aligned bus accesses with byte enables.
// Latency: 2 stall cycles minimum, mem_done in the 3rd cycle; +1 cycle per cycle bus_ready is low.
// Backpressure: holds the bus request until bus_ready (or timeout), stalling the pipeline meanwhile.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   cpu_en            global enable; low freezes FSM, timeout counter and all registers
//   mem_valid/write/size/unsigned/addr/wdata   MEM-stage operation
//   mem_stall         freeze IF..MEM (combinational)
//   mem_done          one-cycle completion pulse; mem_rdata is valid with it
//   mem_align_err     misaligned-access pulse (only with MEM_ALIGN_CHECK_EN, else 0)
//   bus_timeout       sticky flag: an access was aborted for lack of bus_ready
//   bus               mem_access_unit_if master modport
//
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses without a bus
// transaction. Undefined, the low address bits are ignored and the containing unit is accessed.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_align_err,
  output logic        bus_timeout,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateE;

  // Counter value at which one more missing bus_ready aborts the access.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  stateE           state, nextState;
  logic [TO_W-1:0] toCnt;
  logic [1:0]      opLane;
  logic [1:0]      opSize;
  logic            opUnsigned;
  logic            opWrite;
  logic            busReq, busWe;
  logic [3:0]      busBe;
  logic [31:0]     busAddr, busWdata;
  logic [31:0]     rdataReg;
  logic            timeoutFlag;
  logic [3:0]      beIn;
  logic [31:0]     wdataIn;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;
  logic [31:0]     loadFmt;
  logic            toHit;
  logic            misalign;

`ifdef MEM_ALIGN_CHECK_EN
  logic alignErr;

  assign misalign = ((mem_size == 2'b01) && mem_addr[0]) ||
                    (mem_size[1] && (mem_addr[1:0] != 2'b00));

  // Raised together with the IDLE->DONE shortcut, so it is high exactly in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alignErr <= 1'b0;
    end else if (cpu_en) begin
      if (state == IDLE && mem_valid) alignErr <= misalign;
      else if (state == DONE)         alignErr <= 1'b0;
    end
  end

  assign mem_align_err = alignErr;
`else
  assign misalign      = 1'b0;
  assign mem_align_err = 1'b0;
`endif

  // Byte enables and lane-replicated store data from the incoming request.
  always_comb begin
    beIn    = 4'b1111;
    wdataIn = mem_wdata;
    case (mem_size)
      2'b00: begin
        beIn    = 4'b0001 << mem_addr[1:0];
        wdataIn = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        beIn    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdataIn = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting works off the latched operation, not the live MEM-stage inputs.
  assign byteSel = bus.bus_rdata[{opLane, 3'b000} +: 8];
  assign halfSel = bus.bus_rdata[{opLane[1], 4'b0000} +: 16];

  always_comb begin
    loadFmt = bus.bus_rdata;
    case (opSize)
      2'b00:   loadFmt = {{24{byteSel[7] & ~opUnsigned}}, byteSel};
      2'b01:   loadFmt = {{16{halfSel[15] & ~opUnsigned}}, halfSel};
      default: ;
    endcase
  end

  assign toHit = (toCnt == TO_LAST);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state <= IDLE;
    else if (cpu_en) state <= nextState;
  end

  // FSM: next state
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (mem_valid) nextState = misalign ? DONE : ACCESS;
      ACCESS:  if (bus.bus_ready || toHit) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM: outputs. Stall drops in DONE so the pipeline advances exactly once per access.
  always_comb begin
    mem_stall = rst && (((state == IDLE) && mem_valid) || (state == ACCESS));
    mem_done  = (state == DONE);
  end

  // Latched operation, bus registers, load result and timeout bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCnt       <= '0;
      opLane      <= 2'b00;
      opSize      <= 2'b00;
      opUnsigned  <= 1'b0;
      opWrite     <= 1'b0;
      busReq      <= 1'b0;
      busWe       <= 1'b0;
      busBe       <= 4'b0000;
      busAddr     <= 32'h0;
      busWdata    <= 32'h0;
      rdataReg    <= 32'h0;
      timeoutFlag <= 1'b0;
    end else if (cpu_en) begin
      case (state)
        IDLE: if (mem_valid) begin
          opLane     <= mem_addr[1:0];
          opSize     <= mem_size;
          opUnsigned <= mem_unsigned;
          opWrite    <= mem_write;
          rdataReg   <= 32'h0;
          if (!misalign) begin
            busReq   <= 1'b1;
            busWe    <= mem_write;
            busBe    <= beIn;
            busAddr  <= {mem_addr[31:2], 2'b00};
            busWdata <= wdataIn;
          end
        end
        ACCESS: begin
          if (bus.bus_ready) begin
            rdataReg <= opWrite ? 32'h0 : loadFmt;
            busReq   <= 1'b0;
            busWe    <= 1'b0;
            busBe    <= 4'b0000;
          end else if (toHit) begin
            timeoutFlag <= 1'b1;
            rdataReg    <= 32'h0;
            busReq      <= 1'b0;
            busWe       <= 1'b0;
            busBe       <= 4'b0000;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        DONE:    toCnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = busReq;
  assign bus.bus_we    = busWe;
  assign bus.bus_be    = busBe;
  assign bus.bus_addr  = busAddr;
  assign bus.bus_wdata = busWdata;
  assign mem_rdata     = rdataReg;
  assign bus_timeout   = timeoutFlag;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses.
// Latency: expected per-cycle behaviour comes from a transaction-level reference model.
// Backpressure: bus_ready delays and cpu_en freezes are randomized per access.
module tb_mem_access_unit;
  localparam int TO = 6;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic        mem_valid;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_align_err;
  logic        bus_timeout;

  mem_access_unit_if busIf();

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_align_err(mem_align_err), .bus_timeout(bus_timeout), .bus(busIf)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit expTimeout  = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] expBe(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 32'(1 << (a % 4));
    if (sz == 2'd1) return ((a / 2) % 2 == 1) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] expLoad(input logic [1:0] sz, input bit uns,
                                          input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * (a % 4))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (r >> (16 * ((a / 2) % 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return r;
  endfunction

  function automatic bit isMis(input logic [1:0] sz, input logic [31:0] a);
    return ALIGN_EN && (((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0)));
  endfunction

  // One access, entered just after a rising edge with the DUT in IDLE.
  // readyDelay = ACCESS cycles with bus_ready low before it rises.
  task automatic doAccess(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int readyDelay, input bit randFreeze);
    int k;
    int guard;
    bit frozen;
    bit timedOut;
    bit mis;
    logic [31:0] expR;
    mis      = isMis(sz, a);
    timedOut = 1'b0;
    k        = 0;
    guard    = 0;
    mem_valid = 1'b1; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    mem_addr  = a;    mem_wdata = wd; cpu_en = 1'b1;
    busIf.bus_rdata = rd; busIf.bus_ready = 1'b0;
    @(negedge clk);
    checkVal("idle_stall", 32'(mem_stall), 32'd1);
    checkVal("idle_req", 32'(busIf.bus_req), 32'd0);
    if (!mis) begin
      while (1) begin
        @(posedge clk); #1;
        // Live MEM-stage inputs must not disturb the latched access.
        mem_valid = 1'($urandom_range(0, 1));
        mem_addr  = $urandom();
        mem_wdata = $urandom();
        frozen    = randFreeze && (guard < 20) && ($urandom_range(0, 3) == 0);
        cpu_en    = !frozen;
        busIf.bus_ready = frozen ? 1'($urandom_range(0, 1)) : (k >= readyDelay);
        @(negedge clk);
        checkVal("acc_req", 32'(busIf.bus_req), 32'd1);
        checkVal("acc_we", 32'(busIf.bus_we), 32'(wr));
        checkVal("acc_be", 32'(busIf.bus_be), expBe(sz, a));
        checkVal("acc_addr", busIf.bus_addr, a & 32'hFFFF_FFFC);
        checkVal("acc_wdata", busIf.bus_wdata, expWdata(sz, wd));
        checkVal("acc_stall", 32'(mem_stall), 32'd1);
        checkVal("acc_done", 32'(mem_done), 32'd0);
        guard++;
        if (!frozen) begin
          if (k >= readyDelay) break;
          if (k == TO - 1) begin
            timedOut = 1'b1;
            break;
          end
          k++;
        end
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; cpu_en = 1'b1; busIf.bus_ready = 1'b0;
    @(negedge clk);
    expTimeout = expTimeout | timedOut;
    expR = (wr || timedOut || mis) ? 32'h0 : expLoad(sz, uns, a, rd);
    checkVal("done_pulse", 32'(mem_done), 32'd1);
    checkVal("done_stall", 32'(mem_stall), 32'd0);
    checkVal("done_req", 32'(busIf.bus_req), 32'd0);
    checkVal("done_rdata", mem_rdata, expR);
    checkVal("done_alignerr", 32'(mem_align_err), 32'(mis));
    checkVal("done_timeout", 32'(bus_timeout), 32'(expTimeout));
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("idle_done", 32'(mem_done), 32'd0);
    checkVal("idle_nostall", 32'(mem_stall), 32'd0);
    checkVal("idle_noreq", 32'(busIf.bus_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cpu_en = 1'b1; mem_valid = 1'b1; mem_write = 1'b0; mem_size = 2'd0;
    mem_unsigned = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    busIf.bus_rdata = 32'h0; busIf.bus_ready = 1'b0;
    #12;
    checkVal("rst_stall", 32'(mem_stall), 32'd0);
    checkVal("rst_req", 32'(busIf.bus_req), 32'd0);
    checkVal("rst_done", 32'(mem_done), 32'd0);
    checkVal("rst_rdata", mem_rdata, 32'h0);
    checkVal("rst_timeout", 32'(bus_timeout), 32'd0);
    mem_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    doAccess(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          0, 1'b0);
    doAccess(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         32'h80FF_0000, 0, 1'b0);
    doAccess(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         32'h80FF_0000, 0, 1'b0);
    doAccess(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h0,          0, 1'b0);
    doAccess(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         32'h7FFF_0000, 0, 1'b0);
    doAccess(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h1357_9BDF, 5, 1'b0);
    doAccess(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0,         32'hFFFF_FFFF, 99, 1'b0);
    doAccess(1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0,         32'hCAFE_F00D, 0, 1'b0);

    // Reset in the middle of an access
    mem_valid = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_addr = 32'h80;
    busIf.bus_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkVal("midrst_req", 32'(busIf.bus_req), 32'd0);
    checkVal("midrst_stall", 32'(mem_stall), 32'd0);
    checkVal("midrst_timeout", 32'(bus_timeout), 32'd0);
    expTimeout = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    doAccess(1'b0, 2'd2, 1'b0, 32'h0000_0084, 32'h0, 32'h0BAD_CAFE, 1, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      int dly;
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                         : int'($urandom_range(0, 3));
      doAccess(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom(), $urandom(), $urandom(), dly, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
